ctrl_unit: RTL and testbench

- Hardwired, multi-cycle control unit that drives the 16-bit datapath's control-word input.
- Fetches 16-bit instructions from instruction memory and decodes them into CTRWRD, Cin and a data-memory write strobe.
- Holds each control word stable for a fixed execute window, so the datapath's registered B/D buses settle before any register write.
- Samples the datapath's V/C/N/Z flags to resolve conditional branches.

---
 rtl/ctrl_unit_if.sv | 30 +++
 rtl/ctrl_unit.sv | 162 ++++++++++++++++
 tb/tb_ctrl_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ctrl_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ctrl_unit_if : instruction-fetch and datapath-control bundle for ctrl_unit |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
interface ctrl_unit_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] IADDR;
  logic [15:0]     IDATA;
  logic            V;
  logic            C;
  logic            N;
  logic            Z;
  logic [15:0]     CTRWRD;
  logic [15:0]     Cin;
  logic            MW;
  logic            HALTED;

  modport master (
    output IADDR, CTRWRD, Cin, MW, HALTED,
    input  IDATA, V, C, N, Z
  );

  modport slave (
    input  IADDR, CTRWRD, Cin, MW, HALTED,
    output IDATA, V, C, N, Z
  );
endinterface
`default_nettype wire

// File: rtl/ctrl_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ctrl_unit : hardwired multi-cycle control unit for the 16-bit datapath   |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module ctrl_unit #(
  parameter int         PC_W        = 8,
  parameter int         EXEC_CYCLES = 3,
  parameter logic [3:0] FS_PASS     = 4'b0000
) (
  input  wire logic    CLK,
  input  wire logic    RESET,
  ctrl_unit_if.master  bus
);

  localparam int CNT_W = (EXEC_CYCLES > 2) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_pre  = CNT_W'(EXEC_CYCLES - 2);

  localparam logic [2:0] c_op_alu  = 3'b001;
  localparam logic [2:0] c_op_imm  = 3'b010;
  localparam logic [2:0] c_op_ld   = 3'b011;
  localparam logic [2:0] c_op_st   = 3'b100;
  localparam logic [2:0] c_op_br   = 3'b101;
  localparam logic [2:0] c_op_jmp  = 3'b110;
  localparam logic [2:0] c_op_halt = 3'b111;

  typedef enum logic [1:0] {
    S_FETCH0 = 2'd0,
    S_FETCH1 = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t           r_state;
  logic [PC_W-1:0]  r_pc;
  logic [15:0]      r_ir;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_ctrwrd;
  logic [15:0]      r_cin;
  logic             r_mw;
  logic             r_halted;

  // Outputs are registered, so decode targets the instruction and count of the *next* cycle.
  logic [15:0] w_dec_ir;
  logic        w_dec_commit;
  logic [2:0]  w_dr, w_sa, w_sb;
  logic [3:0]  w_fs;
  logic [15:0] w_ctrwrd;
  logic [15:0] w_cin;
  logic        w_mw;

  assign w_dec_ir     = (r_state == S_FETCH1) ? bus.IDATA : r_ir;
  assign w_dec_commit = (r_state == S_EXEC) && (r_cnt == c_pre);
  assign w_dr         = w_dec_ir[12:10];
  assign w_sa         = w_dec_ir[9:7];
  assign w_sb         = w_dec_ir[6:4];
  assign w_fs         = w_dec_ir[3:0];

  always_comb begin
    w_ctrwrd = '0;
    w_cin    = '0;
    w_mw     = 1'b0;
    case (w_dec_ir[15:13])
      c_op_alu: w_ctrwrd = {w_dr, w_sa, w_sb, 1'b0, w_fs, 1'b0, w_dec_commit};
      c_op_imm: begin
        w_ctrwrd = {w_dr, w_sa, 3'b000, 1'b1, w_fs, 1'b0, w_dec_commit};
        w_cin    = {13'b0, w_sb};
      end
      c_op_ld:  w_ctrwrd = {w_dr, w_sa, 3'b000, 1'b0, FS_PASS, 1'b1, w_dec_commit};
      c_op_st: begin
        w_ctrwrd = {3'b000, w_sa, w_sb, 1'b0, FS_PASS, 1'b0, 1'b0};
        w_mw     = w_dec_commit;
      end
      c_op_br:  w_ctrwrd = {3'b000, w_sa, 3'b000, 1'b0, FS_PASS, 1'b0, 1'b0};
      default:  w_ctrwrd = '0;
    endcase
  end

  // Branch resolution uses the live flags on the commit cycle.
  logic [5:0]      w_off6;
  logic [PC_W-1:0] w_offset;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_br_target;
  logic            w_flag;
  logic            w_taken;

  assign w_off6      = {r_ir[12:10], r_ir[6:4]};
  assign w_offset    = {{(PC_W-6){w_off6[5]}}, w_off6};
  assign w_pc_inc    = r_pc + PC_W'(1);
  assign w_br_target = w_pc_inc + w_offset;

  always_comb begin
    w_flag = bus.Z;
    case (r_ir[1:0])
      2'b00:   w_flag = bus.Z;
      2'b01:   w_flag = bus.N;
      2'b10:   w_flag = bus.C;
      default: w_flag = bus.V;
    endcase
  end

  assign w_taken = r_ir[3] | (w_flag ^ r_ir[2]);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_FETCH0;
      r_pc     <= '0;
      r_ir     <= '0;
      r_cnt    <= '0;
      r_ctrwrd <= '0;
      r_cin    <= '0;
      r_mw     <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH0: r_state <= S_FETCH1;
        S_FETCH1: begin
          r_ir     <= bus.IDATA;
          r_cnt    <= '0;
          r_state  <= S_EXEC;
          r_ctrwrd <= w_ctrwrd;
          r_cin    <= w_cin;
          r_mw     <= w_mw;
        end
        S_EXEC: begin
          if (r_cnt == c_last) begin
            r_cnt    <= '0;
            r_ctrwrd <= '0;
            r_cin    <= '0;
            r_mw     <= 1'b0;
            r_state  <= S_FETCH0;
            case (r_ir[15:13])
              c_op_br:   r_pc <= w_taken ? w_br_target : w_pc_inc;
              c_op_jmp:  r_pc <= r_ir[PC_W-1:0];
              c_op_halt: begin
                r_halted <= 1'b1;
                r_state  <= S_HALT;
              end
              default:   r_pc <= w_pc_inc;
            endcase
          end else begin
            r_cnt    <= r_cnt + CNT_W'(1);
            r_ctrwrd <= w_ctrwrd;
            r_cin    <= w_cin;
            r_mw     <= w_mw;
          end
        end
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_FETCH0;
      endcase
    end
  end

  assign bus.IADDR  = r_pc;
  assign bus.CTRWRD = r_ctrwrd;
  assign bus.Cin    = r_cin;
  assign bus.MW     = r_mw;
  assign bus.HALTED = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ctrl_unit : directed self-checking bench for ctrl_unit                |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_ctrl_unit;

  localparam int PC_W        = 8;
  localparam int EXEC_CYCLES = 3;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [15:0] imem [256];

  ctrl_unit_if #(.PC_W(PC_W)) bus ();

  ctrl_unit #(
    .PC_W        (PC_W),
    .EXEC_CYCLES (EXEC_CYCLES),
    .FS_PASS     (4'b0000)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Synchronous instruction memory: data valid one cycle after the address.
  always @(posedge CLK) bus.IDATA <= imem[bus.IADDR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge inside FETCH0; leaves at the negedge of the next FETCH0.
  task automatic run_instr(input logic [7:0] pc, input logic [15:0] cw, input logic [15:0] cw_c,
                           input logic [15:0] cin, input logic mw_c, input logic z);
    bus.Z = z;
    chk("f0_iaddr", bus.IADDR, pc);
    chk("f0_ctrwrd", bus.CTRWRD, 0);
    chk("f0_cin", bus.Cin, 0);
    chk("f0_mw", bus.MW, 0);
    chk("f0_halted", bus.HALTED, 0);
    @(negedge CLK);
    chk("f1_ctrwrd", bus.CTRWRD, 0);
    chk("f1_cin", bus.Cin, 0);
    for (int k = 0; k < EXEC_CYCLES - 1; k++) begin
      @(negedge CLK);
      chk("ex_ctrwrd", bus.CTRWRD, cw);
      chk("ex_cin", bus.Cin, cin);
      chk("ex_mw", bus.MW, 0);
      chk("ex_iaddr", bus.IADDR, pc);
    end
    @(negedge CLK);
    chk("commit_ctrwrd", bus.CTRWRD, cw_c);
    chk("commit_cin", bus.Cin, cin);
    chk("commit_mw", bus.MW, mw_c);
    @(negedge CLK);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    imem[8'h00] = 16'h2CA5;  // ALU-reg DR=3 SA=1 SB=2 FS=0101
    imem[8'h01] = 16'h6A80;  // LD DR=2 SA=5
    imem[8'h02] = 16'h80A0;  // ST SA=1 SB=2
    imem[8'h03] = 16'h4552;  // ALU-imm DR=1 SA=2 imm=5 FS=0010
    imem[8'h04] = 16'hBDE0;  // BR on Z, SA=3, offset -2
    imem[8'h05] = 16'hC0FF;  // JMP 0xFF
    imem[8'hFF] = 16'hA018;  // BR always, offset +1
    bus.V = 1'b0;
    bus.C = 1'b0;
    bus.N = 1'b0;
    bus.Z = 1'b0;

    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_iaddr", bus.IADDR, 8'h00);
    chk("rst_ctrwrd", bus.CTRWRD, 16'h0000);
    chk("rst_mw", bus.MW, 0);
    chk("rst_halted", bus.HALTED, 0);
    RESET = 1'b0;

    run_instr(8'h00, 16'h6514, 16'h6515, 16'h0000, 1'b0, 1'b0);
    run_instr(8'h01, 16'h5402, 16'h5403, 16'h0000, 1'b0, 1'b0);
    run_instr(8'h02, 16'h0500, 16'h0500, 16'h0000, 1'b1, 1'b0);
    run_instr(8'h03, 16'h2848, 16'h2849, 16'h0005, 1'b0, 1'b0);
    run_instr(8'h04, 16'h0C00, 16'h0C00, 16'h0000, 1'b0, 1'b1);  // taken -> 3
    run_instr(8'h03, 16'h2848, 16'h2849, 16'h0005, 1'b0, 1'b0);
    run_instr(8'h04, 16'h0C00, 16'h0C00, 16'h0000, 1'b0, 1'b0);  // not taken -> 5
    run_instr(8'h05, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    run_instr(8'hFF, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);  // wraps to 0x01

    // Abort the LD at 0x01 after its first execute cycle.
    chk("abort_f0_iaddr", bus.IADDR, 8'h01);
    @(negedge CLK);
    @(negedge CLK);
    chk("abort_ex0_ctrwrd", bus.CTRWRD, 16'h5402);
    RESET = 1'b1;
    @(negedge CLK);
    chk("abort_ctrwrd_a", bus.CTRWRD, 16'h0000);
    chk("abort_iaddr", bus.IADDR, 8'h00);
    chk("abort_mw", bus.MW, 0);
    @(negedge CLK);
    chk("abort_ctrwrd_b", bus.CTRWRD, 16'h0000);
    RESET = 1'b0;

    imem[8'h00] = 16'hC020;  // JMP 0x20
    imem[8'h20] = 16'hE000;  // HALT
    run_instr(8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    run_instr(8'h20, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      chk("halt_halted", bus.HALTED, 1);
      chk("halt_iaddr", bus.IADDR, 8'h20);
      chk("halt_ctrwrd", bus.CTRWRD, 16'h0000);
      @(negedge CLK);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
